// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter: ALU op codes,
// FSM state encoding and default widths.
package alu_share_arbiter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SRL = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_grant2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// a tie goes to the port named by ptr.
module alu_share_arbiter_rr_grant2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       grant,
    output logic       grant_any
);

    always_comb begin
        grant_any = |valid;
        grant     = (valid == 2'b11) ? ptr : valid[1];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between two valid/ready requesters with one op in
// flight; operands are held across the ALU edge and results land per port.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [OPW-1:0]   req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_valid0,
    input  logic             rsp_ready0,
    output logic [WIDTH-1:0] rsp_data0,
    output logic             rsp_err0,
    output logic             rsp_valid1,
    input  logic             rsp_ready1,
    output logic [WIDTH-1:0] rsp_data1,
    output logic             rsp_err1,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    logic [1:0]       valid_vec;
    logic [1:0]       rsp_ready_vec;
    logic [OPW-1:0]   op_vec [2];
    logic [WIDTH-1:0] a_vec  [2];
    logic [WIDTH-1:0] b_vec  [2];
    logic             grant;
    logic             grant_any;
    logic             accept;
    logic             sel_supported;
    arb_state_t       state_reg;
    logic             rr_ptr_reg;
    logic             owner_reg;
    logic [OPW-1:0]   alu_op_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;

    assign valid_vec     = {req_valid1, req_valid0};
    assign rsp_ready_vec = {rsp_ready1, rsp_ready0};
    assign op_vec[0]     = req_op0;
    assign op_vec[1]     = req_op1;
    assign a_vec[0]      = req_a0;
    assign a_vec[1]      = req_a1;
    assign b_vec[0]      = req_b0;
    assign b_vec[1]      = req_b1;

    alu_share_arbiter_rr_grant2 u_grant (
        .valid     (valid_vec),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_any (grant_any)
    );

    // A grant only exists while some port is valid, so ready implies valid.
    assign accept        = (state_reg == IDLE) && grant_any;
    assign sel_supported = (op_vec[grant] <= OPW'(ALU_AND));
    assign req_ready0    = accept && !grant;
    assign req_ready1    = accept && grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            owner_reg  <= 1'b0;
            alu_op_reg <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        owner_reg  <= grant;
                        rr_ptr_reg <= ~grant;
                        if (sel_supported) begin
                            alu_op_reg <= op_vec[grant];
                            alu_a_reg  <= a_vec[grant];
                            alu_b_reg  <= b_vec[grant];
                            state_reg  <= ISSUE;
                        end else begin
                            state_reg  <= RESP;
                        end
                    end
                end
                ISSUE:   state_reg <= CAPT;
                CAPT:    state_reg <= RESP;
                RESP:    if (rsp_ready_vec[owner_reg]) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            localparam logic PORT = 1'(gi);
            logic             valid_reg;
            logic             err_reg;
            logic [WIDTH-1:0] data_reg;

            // Non-owner ports never match, so their data/err simply persist.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    data_reg  <= '0;
                end else if (accept && (grant == PORT) && !sel_supported) begin
                    valid_reg <= 1'b1;
                    err_reg   <= 1'b1;
                    data_reg  <= '0;
                end else if ((state_reg == CAPT) && (owner_reg == PORT)) begin
                    valid_reg <= 1'b1;
                    err_reg   <= 1'b0;
                    data_reg  <= alu_result;
                end else if ((state_reg == RESP) && (owner_reg == PORT) && rsp_ready_vec[gi]) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    assign rsp_valid0 = g_rsp[0].valid_reg;
    assign rsp_err0   = g_rsp[0].err_reg;
    assign rsp_data0  = g_rsp[0].data_reg;
    assign rsp_valid1 = g_rsp[1].valid_reg;
    assign rsp_err1   = g_rsp[1].err_reg;
    assign rsp_data1  = g_rsp[1].data_reg;
    assign alu_op     = alu_op_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of grant order, latency and results.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int OW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid0, req_valid1, req_ready0, req_ready1;
    logic [OW-1:0] req_op0, req_op1;
    logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic          rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1, rsp_err0, rsp_err1;
    logic [W-1:0]  rsp_data0, rsp_data1;
    logic [OW-1:0] alu_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_share_arbiter #(.WIDTH(W), .OPW(OW)) dut (
        .clock(clock), .reset(reset),
        .req_valid0(req_valid0), .req_ready0(req_ready0), .req_op0(req_op0),
        .req_a0(req_a0), .req_b0(req_b0),
        .req_valid1(req_valid1), .req_ready1(req_ready1), .req_op1(req_op1),
        .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0), .rsp_data0(rsp_data0), .rsp_err0(rsp_err0),
        .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1), .rsp_data1(rsp_data1), .rsp_err1(rsp_err1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy)
    );

    function automatic logic [W-1:0] spec_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SRL: return a >> b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            default: return '0;
        endcase
    endfunction

    // External ALU: result registered one clock after its operands.
    always @(posedge clock) alu_result <= spec_alu(alu_op, alu_a, alu_b);

    // Protocol monitor: requests held while waiting, never two grants at once.
    logic               hold0_prev = 1'b0, hold1_prev = 1'b0;
    logic [OW+2*W-1:0]  req0_prev, req1_prev;
    always @(posedge clock) begin
        if (!reset) begin
            checks++;
            if (req_ready0 && req_ready1) begin
                errors++;
                $display("FAIL both_ready: req_ready0=%0b req_ready1=%0b required not both 1", req_ready0, req_ready1);
            end
            if (hold0_prev && !(req_valid0 && ({req_op0, req_a0, req_b0} == req0_prev))) begin
                errors++;
                $display("FAIL req_stable0: request changed while waiting");
            end
            if (hold1_prev && !(req_valid1 && ({req_op1, req_a1, req_b1} == req1_prev))) begin
                errors++;
                $display("FAIL req_stable1: request changed while waiting");
            end
        end
        hold0_prev <= req_valid0 && !req_ready0 && !reset;
        hold1_prev <= req_valid1 && !req_ready1 && !reset;
        req0_prev  <= {req_op0, req_a0, req_b0};
        req1_prev  <= {req_op1, req_a1, req_b1};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
        req_op0 = 0; req_a0 = 0; req_b0 = 0; req_op1 = 0; req_a1 = 0; req_b1 = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++;
        if ({rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got v0=%0b v1=%0b e0=%0b e1=%0b busy=%0b required all 0",
                     rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, busy);
        end
        checks++;
        if ({rsp_data0, rsp_data1} !== '0) begin
            errors++;
            $display("FAIL reset_data: got d0=%h d1=%h required 0", rsp_data0, rsp_data1);
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got op=%0d a=%h b=%h required 0", alu_op, alu_a, alu_b);
        end
        checks++;
        if ({req_ready0, req_ready1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_idle: got %0b%0b required 00", req_ready1, req_ready0);
        end
        // Both valid straight out of reset: the pointer favours port 0.
        req_valid0 = 1; req_valid1 = 1;
        #1;
        checks++;
        if ({req_ready1, req_ready0} !== 2'b01) begin
            errors++;
            $display("FAIL reset_tie_grant: got ready1/0=%0b%0b required 01", req_ready1, req_ready0);
        end
        req_valid0 = 0; req_valid1 = 0;
    endtask

    task automatic test_add_basic();
        do_reset();
        @(negedge clock);
        req_valid0 = 1; req_op0 = ALU_ADD; req_a0 = 5; req_b0 = 7; rsp_ready0 = 0;
        #1;
        checks++;
        if (req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL add_ready0: got %0b required 1", req_ready0);
        end
        @(negedge clock);
        req_valid0 = 0;
        checks++;
        if ({alu_op, alu_a, alu_b, busy, rsp_valid0} !== {3'd0, 32'd5, 32'd7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_issue: got op=%0d a=%0d b=%0d busy=%0b v0=%0b required 0/5/7/1/0",
                     alu_op, alu_a, alu_b, busy, rsp_valid0);
        end
        @(negedge clock);
        checks++;
        if (rsp_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL add_early_rsp: got rsp_valid0=%0b required 0", rsp_valid0);
        end
        @(negedge clock);
        checks++;
        if ({rsp_valid0, rsp_data0, rsp_err0} !== {1'b1, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL add_rsp: got v=%0b d=%0d e=%0b required 1/12/0", rsp_valid0, rsp_data0, rsp_err0);
        end
        rsp_ready0 = 1;
        @(negedge clock);
        rsp_ready0 = 0;
        checks++;
        if ({rsp_valid0, busy} !== 2'b00) begin
            errors++;
            $display("FAIL add_done: got v=%0b busy=%0b required 0/0", rsp_valid0, busy);
        end
    endtask

    task automatic test_alternate();
        int exp_g;
        logic [W-1:0] exp_d;
        do_reset();
        @(negedge clock);
        req_valid0 = 1; req_op0 = ALU_OR;  req_a0 = 32'hF0; req_b0 = 32'h0F;
        req_valid1 = 1; req_op1 = ALU_AND; req_a1 = 32'hFF; req_b1 = 32'h3C;
        rsp_ready0 = 1; rsp_ready1 = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            exp_d = (exp_g == 1) ? spec_alu(ALU_AND, 32'hFF, 32'h3C) : spec_alu(ALU_OR, 32'hF0, 32'h0F);
            #1;
            checks++;
            if ({req_ready1, req_ready0} !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got ready1/0=%0b%0b required port %0d", i, req_ready1, req_ready0, exp_g);
            end
            @(negedge clock);
            if (i >= 2) begin
                if (exp_g == 1) req_valid1 = 0; else req_valid0 = 0;
            end
            @(negedge clock);
            @(negedge clock);
            checks++;
            if (exp_g == 1) begin
                if ({rsp_valid1, rsp_data1, rsp_valid0} !== {1'b1, exp_d, 1'b0}) begin
                    errors++;
                    $display("FAIL alt_rsp[%0d]: got v1=%0b d1=%h v0=%0b required 1/%h/0", i, rsp_valid1, rsp_data1, rsp_valid0, exp_d);
                end
            end else begin
                if ({rsp_valid0, rsp_data0, rsp_valid1} !== {1'b1, exp_d, 1'b0}) begin
                    errors++;
                    $display("FAIL alt_rsp[%0d]: got v0=%0b d0=%h v1=%0b required 1/%h/0", i, rsp_valid0, rsp_data0, rsp_valid1, exp_d);
                end
            end
            @(negedge clock);
        end
        rsp_ready0 = 0; rsp_ready1 = 0;
    endtask

    task automatic test_bad_op();
        do_reset();
        @(negedge clock);
        req_valid0 = 1; req_op0 = ALU_OR; req_a0 = 3; req_b0 = 4; rsp_ready0 = 1;
        @(negedge clock);
        req_valid0 = 0;
        repeat (3) @(negedge clock);
        req_valid1 = 1; req_op1 = 3'd5; req_a1 = $urandom; req_b1 = $urandom; rsp_ready1 = 0;
        #1;
        checks++;
        if (req_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL bad_ready1: got %0b required 1", req_ready1);
        end
        @(negedge clock);
        req_valid1 = 0;
        checks++;
        if ({rsp_valid1, rsp_err1, rsp_data1} !== {1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL bad_rsp: got v=%0b e=%0b d=%h required 1/1/0", rsp_valid1, rsp_err1, rsp_data1);
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== {3'd2, 32'd3, 32'd4}) begin
            errors++;
            $display("FAIL bad_alu_hold: got op=%0d a=%0d b=%0d required 2/3/4", alu_op, alu_a, alu_b);
        end
        checks++;
        if ({rsp_valid0, rsp_data0, rsp_err0} !== {1'b0, 32'd7, 1'b0}) begin
            errors++;
            $display("FAIL bad_other_port: got v0=%0b d0=%0d e0=%0b required 0/7/0", rsp_valid0, rsp_data0, rsp_err0);
        end
        rsp_ready1 = 1;
        @(negedge clock);
        rsp_ready1 = 0; rsp_ready0 = 0;
        checks++;
        if ({rsp_valid1, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bad_done: got v1=%0b busy=%0b required 0/0", rsp_valid1, busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clock);
        req_valid0 = 1; req_op0 = ALU_SRL; req_a0 = 32'h80; req_b0 = 3; rsp_ready0 = 0;
        @(negedge clock);
        req_valid0 = 0;
        req_valid1 = 1; req_op1 = ALU_ADD; req_a1 = 2; req_b1 = 3; rsp_ready1 = 1;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid0, rsp_data0, req_ready1} !== {1'b1, 32'h10, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v0=%0b d0=%h ready1=%0b required 1/10/0", i, rsp_valid0, rsp_data0, req_ready1);
            end
            @(negedge clock);
        end
        rsp_ready0 = 1;
        #1;
        checks++;
        if (req_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_early_grant: got ready1=%0b required 0", req_ready1);
        end
        @(negedge clock);
        rsp_ready0 = 0;
        #1;
        checks++;
        if ({req_ready1, rsp_valid0} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant_after: got ready1=%0b v0=%0b required 1/0", req_ready1, rsp_valid0);
        end
        @(negedge clock);
        req_valid1 = 0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({rsp_valid1, rsp_data1} !== {1'b1, 32'd5}) begin
            errors++;
            $display("FAIL bp_port1_rsp: got v1=%0b d1=%0d required 1/5", rsp_valid1, rsp_data1);
        end
        @(negedge clock);
        rsp_ready1 = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clock);
        req_valid0 = 1; req_op0 = ALU_ADD; req_a0 = 9; req_b0 = 9; rsp_ready0 = 1;
        @(posedge clock);
        #2;
        req_valid0 = 0;
        reset = 1;
        #1;
        checks++;
        if ({busy, alu_op, alu_a, alu_b, rsp_valid0, rsp_valid1, req_ready0, req_ready1} !== '0) begin
            errors++;
            $display("FAIL async_clear: got busy=%0b op=%0d a=%0d b=%0d v0=%0b v1=%0b required all 0",
                     busy, alu_op, alu_a, alu_b, rsp_valid0, rsp_valid1);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if ({rsp_valid0, rsp_valid1, busy} !== 3'b000) begin
                errors++;
                $display("FAIL async_no_rsp[%0d]: got v0=%0b v1=%0b busy=%0b required 0", i, rsp_valid0, rsp_valid1, busy);
            end
        end
        req_valid0 = 1; req_op0 = ALU_ADD; req_a0 = 1; req_b0 = 1;
        @(negedge clock);
        req_valid0 = 0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({rsp_valid0, rsp_data0, rsp_err0} !== {1'b1, 32'd2, 1'b0}) begin
            errors++;
            $display("FAIL async_fresh_add: got v0=%0b d0=%0d e0=%0b required 1/2/0", rsp_valid0, rsp_data0, rsp_err0);
        end
        @(negedge clock);
        rsp_ready0 = 0;
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int nrsp = 0;
        do_reset();
        @(negedge clock);
        req_valid1 = 1; req_op1 = ALU_ADD; req_a1 = 32'hFFFF_FFFF; req_b1 = 1; rsp_ready1 = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (req_ready1) acc_cyc.push_back(cyc);
            if (rsp_valid1) begin
                nrsp++;
                checks++;
                if ({rsp_data1, rsp_err1} !== {32'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_data: got d1=%h e1=%0b required 0/0", rsp_data1, rsp_err1);
                end
            end
            @(negedge clock);
            if (acc_cyc.size() == 2) req_valid1 = 0;
        end
        checks++;
        if (acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d accepts spacing %0d required 2 accepts spacing 4",
                     acc_cyc.size(), (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        checks++;
        if (nrsp != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses required 2", nrsp);
        end
        rsp_ready1 = 0;
    endtask

    task automatic test_random();
        logic [1:0]    pend;
        logic [OW-1:0] pop [2];
        logic [W-1:0]  pa [2];
        logic [W-1:0]  pb [2];
        logic [OW-1:0] e_op;
        logic [W-1:0]  e_a, e_b, e_d;
        logic          e_err, last, sup;
        int g, lat, exp_lat;
        do_reset();
        @(negedge clock);
        pend = 2'b00; last = 1'b1; e_op = '0; e_a = '0; e_b = '0;
        for (int n = 0; n < 40 || pend != 2'b00; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (n < 40 && !pend[p] && ($urandom_range(1, 0) == 1 || (p == 1 && !pend[0]))) begin
                    pend[p] = 1'b1;
                    pop[p]  = ($urandom_range(4, 0) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3, 0));
                    pa[p]   = $urandom;
                    pb[p]   = (pop[p] == ALU_SRL) ? 32'($urandom_range(35, 0)) : $urandom;
                end
            end
            req_valid0 = pend[0]; req_op0 = pop[0]; req_a0 = pa[0]; req_b0 = pb[0];
            req_valid1 = pend[1]; req_op1 = pop[1]; req_a1 = pa[1]; req_b1 = pb[1];
            g = (pend == 2'b11) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
            #1;
            checks++;
            if ({req_ready1, req_ready0} !== ((g == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: got ready1/0=%0b%0b required port %0d", n, req_ready1, req_ready0, g);
            end
            @(negedge clock);
            pend[g] = 1'b0;
            last = g[0];
            if (g == 1) req_valid1 = 0; else req_valid0 = 0;
            sup = (pop[g] <= ALU_AND);
            if (sup) begin
                e_op = pop[g]; e_a = pa[g]; e_b = pb[g];
            end
            e_d = sup ? spec_alu(pop[g], pa[g], pb[g]) : '0;
            e_err = !sup;
            exp_lat = sup ? 3 : 1;
            checks++;
            if ({alu_op, alu_a, alu_b} !== {e_op, e_a, e_b}) begin
                errors++;
                $display("FAIL rnd_alu[%0d]: got op=%0d a=%h b=%h required %0d/%h/%h", n, alu_op, alu_a, alu_b, e_op, e_a, e_b);
            end
            lat = 1;
            while (((g == 1) ? rsp_valid1 : rsp_valid0) !== 1'b1 && lat < 8) begin
                @(negedge clock);
                lat++;
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL rnd_latency[%0d]: port %0d op %0d got %0d cycles required %0d", n, g, pop[g], lat, exp_lat);
            end
            repeat ($urandom_range(3, 0) + 1) begin
                checks++;
                if (g == 1) begin
                    if ({rsp_valid1, rsp_data1, rsp_err1, rsp_valid0} !== {1'b1, e_d, e_err, 1'b0}) begin
                        errors++;
                        $display("FAIL rnd_rsp[%0d]: got v1=%0b d1=%h e1=%0b v0=%0b required 1/%h/%0b/0",
                                 n, rsp_valid1, rsp_data1, rsp_err1, rsp_valid0, e_d, e_err);
                    end
                end else begin
                    if ({rsp_valid0, rsp_data0, rsp_err0, rsp_valid1} !== {1'b1, e_d, e_err, 1'b0}) begin
                        errors++;
                        $display("FAIL rnd_rsp[%0d]: got v0=%0b d0=%h e0=%0b v1=%0b required 1/%h/%0b/0",
                                 n, rsp_valid0, rsp_data0, rsp_err0, rsp_valid1, e_d, e_err);
                    end
                end
                @(negedge clock);
            end
            if (g == 1) rsp_ready1 = 1; else rsp_ready0 = 1;
            #1;
            @(negedge clock);
            rsp_ready0 = 0; rsp_ready1 = 0;
            checks++;
            if ({busy, rsp_valid0, rsp_valid1} !== 3'b000) begin
                errors++;
                $display("FAIL rnd_done[%0d]: got busy=%0b v0=%0b v1=%0b required 0", n, busy, rsp_valid0, rsp_valid1);
            end
        end
    endtask

    initial begin
        req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
        req_op0 = 0; req_a0 = 0; req_b0 = 0; req_op1 = 0; req_a1 = 0; req_b1 = 0;
        test_reset();
        test_add_basic();
        test_alternate();
        test_bad_op();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single registered ALU (ops: 0 add, 1 shift-right, 2 or, 3 and; result registered one clock after operands) between two requesters, e.g. the execute stage (port 0) and the address/branch-target unit (port 1).
- Per-port valid/ready request and response handshakes, round-robin grant, one operation in flight.
- Holds ALU operands stable across the ALU's registering edge and captures the result into per-port response registers.

Parameters:
- WIDTH, 32, operand/result width (signed).
- OPW, 3, ALU control width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid0  in  1  port 0 request valid
- req_ready0  out  1  port 0 request accepted this cycle when valid&ready
- req_op0  in  OPW  port 0 ALU control
- req_a0  in  WIDTH  port 0 Operand1
- req_b0  in  WIDTH  port 0 Operand2
- req_valid1, req_ready1, req_op1, req_a1, req_b1: same as above, for port 1
- rsp_valid0  out  1  port 0 response valid
- rsp_ready0  in  1  port 0 response consumed when valid&ready
- rsp_data0  out  WIDTH  port 0 result
- rsp_err0  out  1  port 0 unsupported op (op>=4)
- rsp_valid1, rsp_ready1, rsp_data1, rsp_err1: same as above, for port 1
- alu_op  out  OPW  to ALU control input
- alu_a  out  WIDTH  to ALU Operand1
- alu_b  out  WIDTH  to ALU Operand2
- alu_result  in  WIDTH  from ALU registered result
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, owner=0.
  - alu_op/alu_a/alu_b=0.
  - all rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - Reset mid-operation discards the in-flight op with no response.
- States:
  - IDLE: waiting for a request.
  - ISSUE: operands held, ALU registers its result at the end of this cycle.
  - CAPT: alu_result valid, captured at the end of this cycle.
  - RESP: rsp_valid[owner]=1, waiting for rsp_ready[owner].
- Grant (IDLE only):
  - Only one valid -> that port.
  - Both valid -> port rr_ptr.
  - req_ready_i = (state==IDLE) && grant==i; combinational from the valids and rr_ptr, never asserted for both ports.
- Accept edge (IDLE, valid&ready on port g):
  - owner<=g, rr_ptr<=~g.
  - If op[2]==0: alu_op/a/b <= request fields, state<=ISSUE.
  - If op[2]==1: ALU not driven (alu_* keep previous values), rsp_data<=0, rsp_err<=1, state<=RESP.
- Transitions:
  - ISSUE -> CAPT unconditionally.
  - CAPT: rsp_data[owner]<=alu_result, rsp_err<=0, state<=RESP.
  - RESP: rsp_valid[owner] held with data stable until rsp_ready[owner]; on that edge state<=IDLE.
- Latency and throughput:
  - Supported op: request accepted at edge T, rsp_valid high from T+3; best-case throughput one op per 4 cycles.
  - Unsupported op: rsp_valid high from T+1.
- alu_* hold their values through CAPT and RESP and change only on an accept edge.
- Response registers for the non-owner port keep their last data; rsp_valid stays 0 there.
- Response and new request on the same edge:
  - Not possible, since requests are accepted only in IDLE.
  - A requester may hold req_valid during RESP; it is accepted in the IDLE cycle that follows, which costs one bubble cycle.
- Requests must hold stable while valid&!ready; this is checked by bench assertion, not by the RTL.
- rr_ptr updates only on acceptance. A single requester repeatedly issuing is never blocked.
- Arithmetic is done entirely by the ALU; the arbiter does not modify data widths.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD=0, ALU_SRL=1, ALU_OR=2, ALU_AND=3.
  - State encodings: IDLE=0, ISSUE=1, CAPT=2, RESP=3.
  - WIDTH/OPW defaults.
- Natural sub-module: rr_grant2, a combinational 2-way round-robin picker taking valid[1:0] and ptr and producing grant and grant_any.
- The FSM, operand and response registers stay in the top module.

Test Plan:
- Reset, then port 0 requests add with a=5, b=7 -> req_ready0 same cycle, alu_op=0/a=5/b=7 next cycle; rsp_valid0=1 three cycles after acceptance, rsp_data0=12, rsp_err0=0; busy=0 after rsp_ready0.
- Both ports valid every cycle, port 0 requests or 0xF0|0x0F, port 1 requests and 0xFF&0x3C -> grants alternate 0,1,0,1; responses 0xFF and 0x3C; never both req_ready high.
- Port 1 requests op=5 -> rsp_valid1 one cycle after acceptance, rsp_err1=1, rsp_data1=0; alu_op/a/b unchanged.
- Port 0 requests shift-right a=0x80, b=3, with rsp_ready0 held low 10 cycles -> rsp_valid0 held with rsp_data0=0x10 throughout; port 1 request held valid is not accepted until the cycle after rsp_ready0.
- Reset asserted asynchronously during ISSUE -> all outputs 0 immediately, no response delivered; after release, a fresh add 1+1 returns 2 to the requesting port.
- Port 1 alone issues add -1+1 twice back-to-back -> both accepted (4-cycle spacing), results 0, no starvation from rr_ptr.
